// File: rtl/div_acc_seq_if.sv
// Divide-accelerator bundle: start/operands from ctrl, commit ports back to core.
// master = ctrl/core side, slave = accelerator sequencer.
interface div_acc_seq_if #(
    parameter int DATA_W = 16
);
    logic              StartDiv102;
    logic [DATA_W-1:0] Divident;
    logic [DATA_W-1:0] Divisor;
    logic              Flush103;
    logic              Busy;
    logic              StallPipe;
    logic              M_WrEnAcc;
    logic [15:0]       M_AddrAcc;
    logic [DATA_W-1:0] M_WrDataAcc;
    logic              D_WrEnAcc;
    logic [DATA_W-1:0] D_WrDataAcc;
    logic              DoneAcc;
    logic              DivErr;
    logic [DATA_W-1:0] Quotient;
    logic [DATA_W-1:0] Residue;

    modport master (
        output StartDiv102, Divident, Divisor, Flush103,
        input  Busy, StallPipe, M_WrEnAcc, M_AddrAcc, M_WrDataAcc,
        input  D_WrEnAcc, D_WrDataAcc, DoneAcc, DivErr, Quotient, Residue
    );

    modport slave (
        input  StartDiv102, Divident, Divisor, Flush103,
        output Busy, StallPipe, M_WrEnAcc, M_AddrAcc, M_WrDataAcc,
        output D_WrEnAcc, D_WrDataAcc, DoneAcc, DivErr, Quotient, Residue
    );
endinterface

// File: rtl/div_acc_seq.sv
// Divide-loop accelerator: 16-step restoring divide, then commits the
// loop's end state (count to M[ADDR_Q], residue to M[ADDR_R] and D).
module div_acc_seq #(
    parameter int          DATA_W = 16,
    parameter logic [15:0] ADDR_Q = 16'd1,
    parameter logic [15:0] ADDR_R = 16'd2
) (
    input logic          Clk,
    input logic          ResetN,
    div_acc_seq_if.slave bus
);
    localparam int SW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE, CHK, DIV, FIX, WR_Q, WR_R
    } stateT;

    stateT             state, stateNext;
    logic [DATA_W-1:0] dvd, dsr;
    logic [DATA_W-1:0] q, r;
    logic [DATA_W-1:0] kReg, rReg;
    logic [DATA_W-1:0] quot, resid;
    logic [SW-1:0]     step;
    logic [DATA_W-1:0] rShift;
    logic              rGe;
    logic              badOps;
    logic              startOk;

    assign startOk = bus.StartDiv102 && !bus.Flush103;
    assign rShift  = {r[DATA_W-2:0], dvd[step]};
    assign rGe     = rShift >= dsr;
    // Signed-looking operands would make the software loop behave differently
    assign badOps  = (dsr == '0) || dsr[DATA_W-1] || dvd[DATA_W-1];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (startOk) stateNext = CHK;
            CHK: begin
                if (bus.Flush103 || badOps) stateNext = IDLE;
                else                        stateNext = DIV;
            end
            DIV: begin
                if (bus.Flush103)    stateNext = IDLE;
                else if (step == '0) stateNext = FIX;
            end
            FIX: begin
                if (bus.Flush103) stateNext = IDLE;
                else              stateNext = WR_Q;
            end
            WR_Q:    stateNext = WR_R;
            WR_R:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            dvd   <= '0;
            dsr   <= '0;
            q     <= '0;
            r     <= '0;
            step  <= '0;
            kReg  <= '0;
            rReg  <= '0;
            quot  <= '0;
            resid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startOk) begin
                        dvd <= bus.Divident;
                        dsr <= bus.Divisor;
                    end
                end
                CHK: begin
                    q    <= '0;
                    r    <= '0;
                    step <= SW'(DATA_W - 1);
                end
                DIV: begin
                    r       <= rGe ? rShift - dsr : rShift;
                    q[step] <= rGe;
                    if (step != '0) step <= step - 1'b1;
                end
                FIX: begin
                    // The loop always runs once and stops on residue <= 0
                    if (dvd == '0) begin
                        kReg <= DATA_W'(1);
                        rReg <= '0 - dsr;
                    end else if (r == '0) begin
                        kReg <= q;
                        rReg <= '0;
                    end else begin
                        kReg <= q + DATA_W'(1);
                        rReg <= r - dsr;
                    end
                end
                WR_R: begin
                    quot  <= kReg;
                    resid <= rReg;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.M_WrEnAcc   = 1'b0;
        bus.M_AddrAcc   = '0;
        bus.M_WrDataAcc = '0;
        bus.D_WrEnAcc   = 1'b0;
        bus.D_WrDataAcc = '0;
        bus.DoneAcc     = 1'b0;
        unique case (1'b1)
            state == WR_Q: begin
                bus.M_WrEnAcc   = 1'b1;
                bus.M_AddrAcc   = ADDR_Q;
                bus.M_WrDataAcc = kReg;
            end
            state == WR_R: begin
                bus.M_WrEnAcc   = 1'b1;
                bus.M_AddrAcc   = ADDR_R;
                bus.M_WrDataAcc = rReg;
                bus.D_WrEnAcc   = 1'b1;
                bus.D_WrDataAcc = rReg;
                bus.DoneAcc     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Busy      = state != IDLE;
    assign bus.StallPipe = state != IDLE;
    assign bus.DivErr    = (state == CHK) && badOps && !bus.Flush103;
    assign bus.Quotient  = quot;
    assign bus.Residue   = resid;
endmodule

// File: doc/div_acc_seq.md
Name:
div_acc_seq

Overview:
- Sequencer for the divide accelerator. It is started by StartDiv102 when the controller recognises the repeated-subtraction divide loop.
- It replaces the loop with a 16-step restoring divide, then commits the loop's architectural end state: M[1] = iteration count, M[2] = final residue, D = final residue.
- While it runs it holds the fetch/decode pipeline frozen.
- It sits beside ctrl and drives dedicated memory and D-register write ports, which the core muxes over its normal write-back.

Parameters:
- DATA_W, 16, datapath width (Divident, Divisor, results).
- ADDR_Q, 16'd1, data-memory address receiving the iteration count (loop variable X1).
- ADDR_R, 16'd2, data-memory address receiving the final residue (loop variable X2).

Ports:
- Clk in 1: core clock; all state changes on rising edge.
- ResetN in 1: reset, asynchronous, active-low.
- StartDiv102 in 1: single-cycle start from ctrl.
- Divident in DATA_W: dividend, sampled on start.
- Divisor in DATA_W: divisor, sampled on start.
- Flush103 in 1: jump-flush from stage 103.
- Busy out 1: high in any non-IDLE state.
- StallPipe out 1: freezes PC/Inst101 update; equals Busy.
- M_WrEnAcc out 1: memory write strobe.
- M_AddrAcc out 16: memory write address.
- M_WrDataAcc out DATA_W: memory write data.
- D_WrEnAcc out 1: D-register write strobe.
- D_WrDataAcc out DATA_W: D-register write data.
- DoneAcc out 1: one-cycle pulse, result committed.
- DivErr out 1: one-cycle pulse, operands unsupported, nothing committed.
- Quotient out DATA_W: last committed count; held.
- Residue out DATA_W: last committed residue; held.

Behaviour:
- Reset (ResetN=0, async):
  - state=IDLE, step counter=0.
  - All outputs 0; Quotient/Residue = 0.
  - Internal q/r/operand registers cleared.
- States: IDLE, CHK, DIV, FIX, WR_Q, WR_R.
- IDLE:
  - StartDiv102=1 && Flush103=0 → latch Divident/Divisor, go to CHK.
  - Start together with Flush103=1 → ignored.
  - Start while not IDLE → ignored, never queued.
- CHK (1 cycle):
  - If Divisor==0, or Divisor[15]=1, or Divident[15]=1: pulse DivErr, go to IDLE, no writes. The software loop then executes normally.
  - Otherwise clear q/r and set step=15, go to DIV.
- DIV (16 cycles), one restoring step per cycle, MSB first:
  - r' = {r[14:0], dvd[step]}.
  - If r' >= divisor (unsigned): r = r' − divisor and q[step] = 1; else r = r' and q[step] = 0.
  - Leave for FIX when step==0; otherwise step decrements.
- FIX (1 cycle), reproducing the loop semantics. The loop runs at least once and exits on residue ≤ 0:
  - Dividend==0 → K=1, R=−divisor.
  - Else r==0 → K=q, R=0.
  - Else → K=q+1, R=r−divisor.
  - All arithmetic is 16-bit two's complement, wrap ignored.
- WR_Q (1 cycle): M_WrEnAcc=1, M_AddrAcc=ADDR_Q, M_WrDataAcc=K.
- WR_R (1 cycle):
  - M_WrEnAcc=1, M_AddrAcc=ADDR_R, M_WrDataAcc=R.
  - D_WrEnAcc=1, D_WrDataAcc=R.
  - DoneAcc=1; Quotient←K, Residue←R registered on the same edge. Go to IDLE.
  - StallPipe drops the cycle after WR_R.
- Latency:
  - Start seen in cycle 0 → CHK c1, DIV c2–c17, FIX c18, WR_Q c19, WR_R/DoneAcc c20.
  - Busy is high c1–c20.
- Outside WR_Q/WR_R: M_WrEnAcc=0 and D_WrEnAcc=0. Address and data outputs are 0 when not enabled.
- Flush103=1:
  - In CHK/DIV/FIX: abort to IDLE next cycle, no writes, no DoneAcc.
  - In WR_Q/WR_R: ignored; the commit completes atomically.
- ResetN low at any point: immediate IDLE; any partial commit is not continued.

Test Plan:
- Divident=20000, Divisor=10 → DIV 16 cycles. WR_Q writes M[1]=2000, WR_R writes M[2]=0 and D=0. DoneAcc at start+20; Quotient=2000, Residue=0.
- Divident=7, Divisor=2 → M[1]=4, M[2]=0xFFFF, D=0xFFFF.
- Divident=0, Divisor=5 → M[1]=1, M[2]=0xFFFB.
- Divisor=0, Divident=9 → DivErr pulse at start+1. No M_WrEnAcc/D_WrEnAcc/DoneAcc; Busy high one cycle only.
- Flush103 pulsed at start+6 (mid-DIV) → IDLE at start+7, no writes. A new StartDiv102 at start+9 is accepted and completes normally. A second StartDiv102 pulsed at start+4 of a run is ignored.
- ResetN asserted at start+19 (WR_Q) → outputs 0 immediately, no M[2]/D write, no DoneAcc; Quotient/Residue = 0.
